// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   pc;
  } wb_req_t;

  // x0 is hardwired to zero: such writes occupy a slot but never reach the file
  function automatic logic wb_req_is_x0(input wb_req_t req);
    return (req.addr == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback requests for the slow port, with per-entry
// destination-address match vectors used for RAW busy detection.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wb_req_t           push_req_i,
  input  logic              pop_i,
  output wb_req_t           head_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic [REG_AW-1:0] match_addr_1_i,
  input  logic [REG_AW-1:0] match_addr_2_i,
  output logic [DEPTH-1:0]  match_1_o,
  output logic [DEPTH-1:0]  match_2_o
);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] ofs;

  // pointers and occupancy; reset empties the buffer without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // storage write; entry contents are only meaningful when qualified by count
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_req_i;
  end

  // an entry is live when its distance from the read pointer is below count
  always_comb begin
    match_1_o = '0;
    match_2_o = '0;
    ofs       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ofs = PW'(i) - rd_ptr_q;
      if (CW'(ofs) < count_q) begin
        match_1_o[i] = (mem_q[i].addr == match_addr_1_i);
        match_2_o[i] = (mem_q[i].addr == match_addr_2_i);
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write-port front end for the register file: merges ALU (fast) and
// multi-cycle (slow) writebacks, tracks pending writes, requests a stall when
// the slow queue head has waited too long.
module rf_write_arbiter
  import rf_wb_pkg::*;
#(
  parameter int  XLEN         = 32,
  parameter int  DEPTH        = 4,
  parameter int  STARVE_LIMIT = 8,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fast_valid,
  input  logic [4:0]       fast_addr,
  input  logic [XLEN-1:0]  fast_data,
  input  logic [XLEN-1:0]  fast_pc,
  input  logic             slow_valid,
  output logic             slow_ready,
  input  logic [4:0]       slow_addr,
  input  logic [XLEN-1:0]  slow_data,
  input  logic [XLEN-1:0]  slow_pc,
  input  logic             rsv_valid,
  input  logic [4:0]       rsv_addr,
  input  logic [4:0]       chk_addr_1,
  input  logic [4:0]       chk_addr_2,
  output logic             busy_1,
  output logic             busy_2,
  output logic             stall_req,
  output logic             rf_write_en,
  output logic [4:0]       rf_write_addr,
  output logic [XLEN-1:0]  rf_write_data,
  output logic [XLEN-1:0]  rf_pc,
  output logic [CW-1:0]    q_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t          fast_req, slow_req, head_req, sel_req, out_q;
  logic             out_en_q;
  logic             q_full, q_empty, slow_fire, push, pop;
  logic             sel_vld, sel_slow;
  logic [DEPTH-1:0] match_1, match_2;
  logic [NREG-1:0]  sb_q, sb_d, sb_set, sb_clr;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             stall_q;

  assign fast_req   = '{addr: fast_addr, data: fast_data, pc: fast_pc};
  assign slow_req   = '{addr: slow_addr, data: slow_data, pc: slow_pc};
  assign slow_ready = (q_count < CW'(DEPTH));
  assign slow_fire  = slow_valid && slow_ready;
  assign pop        = !fast_valid && !q_empty;
  // bypass only when nothing else competes and nothing older is queued
  assign push       = slow_fire && (fast_valid || !q_empty);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_i         (push),
    .push_req_i     (slow_req),
    .pop_i          (pop),
    .head_o         (head_req),
    .count_o        (q_count),
    .full_o         (q_full),
    .empty_o        (q_empty),
    .match_addr_1_i (chk_addr_1),
    .match_addr_2_i (chk_addr_2),
    .match_1_o      (match_1),
    .match_2_o      (match_2)
  );

  // fixed-priority source select: fast, then queue head, then slow bypass
  always_comb begin
    sel_req  = fast_req;
    sel_vld  = 1'b0;
    sel_slow = 1'b0;
    if (fast_valid) begin
      sel_vld = 1'b1;
    end else if (!q_empty) begin
      sel_req  = head_req;
      sel_vld  = 1'b1;
      sel_slow = 1'b1;
    end else if (slow_fire) begin
      sel_req  = slow_req;
      sel_vld  = 1'b1;
      sel_slow = 1'b1;
    end
  end

  // scoreboard next state: a reservation outranks a same-cycle retire
  always_comb begin
    sb_set           = '0;
    sb_clr           = '0;
    sb_set[rsv_addr] = rsv_valid;
    sb_clr[sel_req.addr] = sel_slow;
    sb_d             = (sb_q & ~sb_clr) | sb_set;
    sb_d[0]          = 1'b0;
  end

  // head-of-queue wait counter, saturating at the limit
  always_comb begin
    if (pop || q_empty)                   cnt_d = '0;
    else if (cnt_q >= SW'(STARVE_LIMIT))  cnt_d = cnt_q;
    else                                  cnt_d = cnt_q + SW'(1);
  end

  // output register, scoreboard and starvation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q <= 1'b0;
      out_q    <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      out_en_q <= sel_vld && !wb_req_is_x0(sel_req);
      if (sel_vld) out_q <= sel_req;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      stall_q  <= (cnt_d >= SW'(STARVE_LIMIT));
    end
  end

  // the entry on rf_write_* is already out of the queue and the scoreboard
  assign busy_1 = (chk_addr_1 != '0) && (sb_q[chk_addr_1] || (|match_1));
  assign busy_2 = (chk_addr_2 != '0) && (sb_q[chk_addr_2] || (|match_2));

  assign stall_req     = stall_q;
  assign rf_write_en   = out_en_q;
  assign rf_write_addr = out_q.addr;
  assign rf_write_data = out_q.data;
  assign rf_pc         = out_q.pc;

  a_fast_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(fast_valid && stall_q));
  a_rsv_twice: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsv_valid && (rsv_addr != '0) && sb_q[rsv_addr]));

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fast_valid, slow_valid, slow_ready, rsv_valid;
  logic [4:0]  fast_addr, slow_addr, rsv_addr, chk_addr_1, chk_addr_2;
  logic [31:0] fast_data, fast_pc, slow_data, slow_pc;
  logic        busy_1, busy_2, stall_req, rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data, rf_pc;
  logic [2:0]  q_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  rf_write_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fast_valid    (fast_valid),
    .fast_addr     (fast_addr),
    .fast_data     (fast_data),
    .fast_pc       (fast_pc),
    .slow_valid    (slow_valid),
    .slow_ready    (slow_ready),
    .slow_addr     (slow_addr),
    .slow_data     (slow_data),
    .slow_pc       (slow_pc),
    .rsv_valid     (rsv_valid),
    .rsv_addr      (rsv_addr),
    .chk_addr_1    (chk_addr_1),
    .chk_addr_2    (chk_addr_2),
    .busy_1        (busy_1),
    .busy_2        (busy_2),
    .stall_req     (stall_req),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_pc         (rf_pc),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  // monitor: every register-file write must match the next expected one
  always @(negedge clk) begin
    if (rst_n && rf_write_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: got write x%0d=%h pc=%h, required no write",
                 rf_write_addr, rf_write_data, rf_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_write_addr !== mon_e.addr || rf_write_data !== mon_e.data || rf_pc !== mon_e.pc) begin
          n_errors++;
          $display("FAIL wb_payload: got x%0d=%h pc=%h, required x%0d=%h pc=%h",
                   rf_write_addr, rf_write_data, rf_pc, mon_e.addr, mon_e.data, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.addr = a; e.data = d; e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    fast_valid = 1'b0;
    slow_valid = 1'b0;
    rsv_valid  = 1'b0;
  endtask

  task automatic drive_fast(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    fast_valid = 1'b1; fast_addr = a; fast_data = d; fast_pc = p;
    push_exp(a, d, p);
  endtask

  task automatic drive_slow(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    slow_valid = 1'b1; slow_addr = a; slow_data = d; slow_pc = p;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    fast_addr = '0; fast_data = '0; fast_pc = '0;
    slow_addr = '0; slow_data = '0; slow_pc = '0;
    rsv_addr = '0; chk_addr_1 = 5'd5; chk_addr_2 = 5'd7;

    // reset values, before and after a clock pulse
    #1;
    chk("rst_wr_en", 32'(rf_write_en), 32'd0);
    chk("rst_addr", 32'(rf_write_addr), 32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_pc", rf_pc, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_qcount", 32'(q_count), 32'd0);
    chk("rst_slow_ready", 32'(slow_ready), 32'd1);
    chk("rst_busy", {30'd0, busy_1, busy_2}, 32'd0);
    step();
    chk("rst_clk_wr_en", 32'(rf_write_en), 32'd0);
    chk("rst_clk_qcount", 32'(q_count), 32'd0);
    rst_n = 1'b1;
    step();

    // fast path
    drive_fast(5'd5, 32'hDEADBEEF, 32'h100);
    chk("fast_busy_pre", 32'(busy_1), 32'd0);
    step();
    idle();
    chk("fast_wr_en", 32'(rf_write_en), 32'd1);
    chk("fast_busy_post", 32'(busy_1), 32'd0);
    step();
    chk("fast_wr_en_drop", 32'(rf_write_en), 32'd0);

    // reservation then slow bypass retire
    chk_addr_1 = 5'd7;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    chk("rsv_busy_pre", 32'(busy_1), 32'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("rsv_busy_held", 32'(busy_1), 32'd1);
      if (i < 2) step();
    end
    drive_slow(5'd7, 32'h1234, 32'h200);
    push_exp(5'd7, 32'h1234, 32'h200);
    step();
    idle();
    chk("byp_wr_en", 32'(rf_write_en), 32'd1);
    chk("byp_busy_clear", 32'(busy_1), 32'd0);
    chk("byp_qcount", 32'(q_count), 32'd0);

    // contention: fast held, four slow writes queue up, head starves
    for (int k = 0; k < 9; k++) begin
      drive_fast(5'(16 + k), 32'hF000_0000 + 32'(k), 32'h500 + 32'(4 * k));
      if (k < 4) drive_slow(5'(k + 1), 32'h1000 + 32'(k), 32'h300 + 32'(4 * k));
      else if (k == 4) drive_slow(5'd30, 32'hBADBAD, 32'h0);
      else slow_valid = 1'b0;
      step();
      if (k == 3) begin
        chk("full_qcount", 32'(q_count), 32'd4);
        chk("full_slow_ready", 32'(slow_ready), 32'd0);
      end
      if (k == 4) chk("full_no_accept", 32'(q_count), 32'd4);
      if (k == 7) chk("starve_not_yet", 32'(stall_req), 32'd0);
      if (k == 8) chk("starve_stall", 32'(stall_req), 32'd1);
    end
    idle();
    for (int j = 0; j < 4; j++) push_exp(5'(j + 1), 32'h1000 + 32'(j), 32'h300 + 32'(4 * j));
    for (int j = 0; j < 4; j++) begin
      step();
      chk("drain_wr_en", 32'(rf_write_en), 32'd1);
      chk("drain_order", 32'(rf_write_addr), 32'(j + 1));
      if (j == 0) begin
        chk("drain_stall_clear", 32'(stall_req), 32'd0);
        chk("drain_qcount", 32'(q_count), 32'd3);
      end
    end
    step();
    chk("drain_empty", 32'(q_count), 32'd0);

    // x0 write consumes its slot but is never written
    drive_slow(5'd0, 32'h0BAD, 32'h600);
    step();
    idle();
    chk("x0_wr_en", 32'(rf_write_en), 32'd0);

    // same-cycle retire and reservation of x9: set wins
    chk_addr_2 = 5'd9;
    drive_slow(5'd9, 32'h9999, 32'h400);
    push_exp(5'd9, 32'h9999, 32'h400);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    step();
    idle();
    chk("setwins_busy", 32'(busy_2), 32'd1);
    drive_slow(5'd9, 32'h9A9A, 32'h404);
    push_exp(5'd9, 32'h9A9A, 32'h404);
    step();
    idle();
    chk("retire_x9_busy", 32'(busy_2), 32'd0);

    // async reset with three queued entries and a reservation outstanding
    chk_addr_1 = 5'd15;
    chk_addr_2 = 5'd12;
    for (int k = 0; k < 3; k++) begin
      drive_fast(5'(21 + k), 32'hA0 + 32'(k), 32'h700 + 32'(4 * k));
      drive_slow(5'(11 + k), 32'hB0 + 32'(k), 32'h800 + 32'(4 * k));
      rsv_valid = (k == 0); rsv_addr = 5'd15;
      step();
    end
    idle();
    chk("prerst_qcount", 32'(q_count), 32'd3);
    chk("prerst_busy_sb", 32'(busy_1), 32'd1);
    chk("prerst_busy_q", 32'(busy_2), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_qcount", 32'(q_count), 32'd0);
    chk("arst_busy_sb", 32'(busy_1), 32'd0);
    chk("arst_busy_q", 32'(busy_2), 32'd0);
    chk("arst_slow_ready", 32'(slow_ready), 32'd1);
    chk("arst_wr_en", 32'(rf_write_en), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("postrst_wr_en", 32'(rf_write_en), 32'd0);
    end
    chk("postrst_qcount", 32'(q_count), 32'd0);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
